dcache_mshr: RTL and testbench
==============================

Name: dcache_mshr

Overview:
- Miss-status holding register file between the Dcache controller and the data memory port.
- Accepts block-miss load requests and issues them to memory as BUS_LOAD.
- Records each transaction tag returned by memory and matches completion tags back to the request.
- Delivers fill data (block address, data, LSQ index) to the Dcache and LSQ; lets loads to different blocks overlap.

Parameters:
NUM_MSHR, 4, number of outstanding-miss entries (2..15)
LSQ_IDX_W, 3, width of the LSQ index carried with each miss

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  controller presents a load miss
req_addr  input  64  miss byte address
req_lsq_idx  input  LSQ_IDX_W  requesting LSQ entry
req_ready  output  1  request accepted this cycle
req_conflict  output  1  request targets a block already pending; not accepted
mem_busy  input  1  controller owns the memory port this cycle (writeback store)
proc2Dmem_command  output  BUS_COMMAND  BUS_LOAD or BUS_NONE
proc2Dmem_addr  output  64  block-aligned issue address
Dmem2proc_response  input  4  transaction tag for this cycle's command; 0 = rejected
Dmem2proc_tag  input  4  completing transaction tag; 0 = none
Dmem2proc_data  input  64  data for the completing tag
fill_valid  output  1  fill outputs valid
fill_addr  output  64  block-aligned address of the fill
fill_data  output  64  fill data
fill_lsq_idx  output  LSQ_IDX_W  LSQ entry to wake
occupancy  output  $clog2(NUM_MSHR+1)  number of non-INVALID entries
full  output  1  occupancy == NUM_MSHR

Behaviour:
- Entry state ENTRY_STATE: INVALID, WAIT_ISSUE, WAIT_DATA.
- Each entry stores block address {addr[63:3],3'b0}, lsq_idx and mem_tag[3:0].
- Reset (asynchronous, any cycle, including mid-transaction):
  - All entries INVALID.
  - fill_valid=0, fill_addr=0, fill_data=0, fill_lsq_idx=0, occupancy=0, full=0.
  - Outstanding memory transactions are abandoned; their later completion tags match nothing and are ignored.
- Allocation (combinational decision, registered update):
  - req_conflict = req_valid && some non-INVALID entry holds the same block address.
  - req_ready = req_valid && !req_conflict && a free entry existed at the start of the cycle.
  - On req_ready, the lowest-index INVALID entry becomes WAIT_ISSUE on the next edge.
  - An entry freed in the same cycle is not reusable until the next cycle.
  - When full, req_ready=0 and req_conflict follows the same rule.
- Issue:
  - If !mem_busy and any entry is WAIT_ISSUE, drive BUS_LOAD with the block address of the lowest-index WAIT_ISSUE entry.
  - Otherwise drive BUS_NONE and addr 0.
  - Issue is combinational from registered state, so a request accepted in cycle N can issue no earlier than N+1.
  - Dmem2proc_response!=0 in the issue cycle: entry becomes WAIT_DATA with mem_tag=response.
  - Dmem2proc_response==0: entry stays WAIT_ISSUE and retries next eligible cycle.
  - mem_busy forces BUS_NONE; Dmem2proc_response is ignored that cycle.
- Completion:
  - Dmem2proc_tag!=0 is compared against all WAIT_DATA entries' mem_tag.
  - On a match, the entry becomes INVALID on the next edge.
  - On the same edge the fill registers load: fill_valid=1, entry address, Dmem2proc_data, entry lsq_idx. Fill latency is one cycle after the completion tag.
  - fill_valid deasserts on the following cycle unless another completion occurs.
  - No match (e.g. a writeback store tag): ignored, fill_valid=0.
  - Memory never reuses a live tag, so at most one entry matches.
- Simultaneous events in one cycle:
  - Allocation, issue, and completion all proceed independently.
  - A completing entry cannot also issue, because it is WAIT_DATA.
  - occupancy next = occupancy + alloc - complete.
- Assertions:
  - Two WAIT_DATA entries with equal mem_tag is an error.
  - Two valid entries with equal block address is an error.

Decomposition:
- Shared package: BUS_COMMAND (existing), new ENTRY_STATE enum, MSHR_ENTRY struct (state, addr, lsq_idx, mem_tag), DCACHE_BLOCK_OFFSET constant.
- One natural sub-module, mshr_pri_enc: parameterised lowest-index priority encoder used for both free-entry selection and issue selection.

Test Plan:
- Reset, one miss at 0x1008 idx 2, response 5, tag 5 three cycles later with data 0xDEAD -> BUS_LOAD addr 0x1008; fill_valid one cycle after tag with addr 0x1008, data 0xDEAD, idx 2; occupancy 1->0.
- Response 0 twice then 7 -> BUS_LOAD repeated three consecutive cycles; entry WAIT_DATA tag 7 after the third.
- Four misses to distinct blocks, fifth request -> full=1, req_ready=0; completion of tag 3 -> req_ready=1 only in the cycle after the free.
- Second miss to 0x1000 while 0x1004 pending -> req_conflict=1, req_ready=0, occupancy unchanged.
- mem_busy=1 with a WAIT_ISSUE entry pending -> BUS_NONE held; issue happens the first cycle mem_busy=0.
- Out-of-order completion: tags 4 then 2 for issue order 2,4 -> fills in completion order with correct lsq_idx; unmatched tag 9 -> no fill; reset asserted while WAIT_DATA -> all outputs 0 immediately, later tag ignored.

Source files
------------

// File: rtl/dcache_mshr_pkg.sv
// Shared types for the data-cache miss-status holding register file.
//   BUS_COMMAND         : memory port command encoding used by the Dmem bus
//   ENTRY_STATE         : lifecycle of one outstanding-miss entry
//   MSHR_ENTRY          : per-entry payload (state, block address, LSQ index, memory tag)
//   DCACHE_BLOCK_OFFSET : log2 of the cache block size in bytes
//   block_addr()        : clears the in-block offset bits of a byte address
package dcache_mshr_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        INVALID    = 2'h0,
        WAIT_ISSUE = 2'h1,
        WAIT_DATA  = 2'h2
    } ENTRY_STATE;

    localparam int DCACHE_BLOCK_OFFSET = 3;

    // Entries hold the LSQ index in a fixed-width field so the struct can live
    // in the package; the top narrows it back to LSQ_IDX_W on the way out.
    localparam int MSHR_LSQ_IDX_MAX_W = 8;

    typedef struct packed {
        ENTRY_STATE                    state;
        logic [63:0]                   addr;
        logic [MSHR_LSQ_IDX_MAX_W-1:0] lsq_idx;
        logic [3:0]                    mem_tag;
    } MSHR_ENTRY;

    function automatic logic [63:0] block_addr(input logic [63:0] byte_addr);
        return {byte_addr[63:DCACHE_BLOCK_OFFSET], {DCACHE_BLOCK_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_mshr_if.sv
// Bundle of every signal between the MSHR file and its neighbours:
//   request side  : req_valid/req_addr/req_lsq_idx in, req_ready/req_conflict out
//   memory side   : mem_busy, Dmem2proc_response/tag/data in,
//                   proc2Dmem_command/addr out
//   fill side     : fill_valid/fill_addr/fill_data/fill_lsq_idx out
//   status        : occupancy, full out
// modport slave  : the MSHR file itself
// modport master : controller / memory model driving the MSHR file
interface dcache_mshr_if
    import dcache_mshr_pkg::*;
#(
    parameter int NUM_MSHR  = 4,
    parameter int LSQ_IDX_W = 3
);
    localparam int OCC_W = $clog2(NUM_MSHR + 1);

    logic                 req_valid;
    logic [63:0]          req_addr;
    logic [LSQ_IDX_W-1:0] req_lsq_idx;
    logic                 req_ready;
    logic                 req_conflict;

    logic                 mem_busy;
    BUS_COMMAND           proc2Dmem_command;
    logic [63:0]          proc2Dmem_addr;
    logic [3:0]           Dmem2proc_response;
    logic [3:0]           Dmem2proc_tag;
    logic [63:0]          Dmem2proc_data;

    logic                 fill_valid;
    logic [63:0]          fill_addr;
    logic [63:0]          fill_data;
    logic [LSQ_IDX_W-1:0] fill_lsq_idx;

    logic [OCC_W-1:0]     occupancy;
    logic                 full;

    modport slave (
        input  req_valid, req_addr, req_lsq_idx,
        input  mem_busy, Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
        output req_ready, req_conflict,
        output proc2Dmem_command, proc2Dmem_addr,
        output fill_valid, fill_addr, fill_data, fill_lsq_idx,
        output occupancy, full
    );

    modport master (
        output req_valid, req_addr, req_lsq_idx,
        output mem_busy, Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
        input  req_ready, req_conflict,
        input  proc2Dmem_command, proc2Dmem_addr,
        input  fill_valid, fill_addr, fill_data, fill_lsq_idx,
        input  occupancy, full
    );

endinterface

// File: rtl/dcache_mshr_pri_enc.sv
// Lowest-index priority encoder.
//   req   : one request bit per entry
//   found : at least one request bit is set
//   idx   : index of the lowest set bit (0 when found is low)
module mshr_pri_enc #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk from the top down so the last hit written is the lowest index.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/dcache_mshr.sv
// Miss-status holding register file between the Dcache controller and the
// data memory port. Accepts block-miss loads, issues them as BUS_LOAD, binds
// each to the transaction tag memory returns, and on completion delivers the
// block address, data and LSQ index of the waiting miss.
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : dcache_mshr_if.slave (request, memory, fill and status signals)
module dcache_mshr
    import dcache_mshr_pkg::*;
#(
    parameter int NUM_MSHR  = 4,
    parameter int LSQ_IDX_W = 3
) (
    input logic          clock,
    input logic          reset,
    dcache_mshr_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_MSHR);
    localparam int OCC_W = $clog2(NUM_MSHR + 1);

    MSHR_ENTRY entry_q [NUM_MSHR];
    logic [OCC_W-1:0] occ_q;

    logic                 fill_valid_q;
    logic [63:0]          fill_addr_q;
    logic [63:0]          fill_data_q;
    logic [LSQ_IDX_W-1:0] fill_lsq_idx_q;

    logic [NUM_MSHR-1:0] free_vec;
    logic [NUM_MSHR-1:0] issue_vec;
    logic [NUM_MSHR-1:0] hit_vec;
    logic [NUM_MSHR-1:0] done_vec;

    logic             free_found, issue_found, done_found;
    logic [IDX_W-1:0] free_idx, issue_idx, done_idx;

    logic [63:0] req_blk;
    logic        alloc;
    logic        issue;
    logic        issue_ack;

    logic dup_tag;
    logic dup_addr;

    // Per-entry classification, all from registered state plus this cycle's inputs.
    always_comb begin
        req_blk   = block_addr(bus.req_addr);
        free_vec  = '0;
        issue_vec = '0;
        hit_vec   = '0;
        done_vec  = '0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            free_vec[i]  = (entry_q[i].state == INVALID);
            issue_vec[i] = (entry_q[i].state == WAIT_ISSUE);
            hit_vec[i]   = (entry_q[i].state != INVALID) && (entry_q[i].addr == req_blk);
            done_vec[i]  = (entry_q[i].state == WAIT_DATA) &&
                           (bus.Dmem2proc_tag != 4'h0) &&
                           (entry_q[i].mem_tag == bus.Dmem2proc_tag);
        end
    end

    mshr_pri_enc #(.N(NUM_MSHR), .IDX_W(IDX_W)) u_free_enc (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    mshr_pri_enc #(.N(NUM_MSHR), .IDX_W(IDX_W)) u_issue_enc (
        .req   (issue_vec),
        .found (issue_found),
        .idx   (issue_idx)
    );

    // Memory never has two live copies of a tag, so at most one bit is set here.
    mshr_pri_enc #(.N(NUM_MSHR), .IDX_W(IDX_W)) u_done_enc (
        .req   (done_vec),
        .found (done_found),
        .idx   (done_idx)
    );

    // A conflicting request is refused even when the matching entry completes
    // this cycle; the free check only sees entries free before this edge.
    assign alloc            = bus.req_valid && !(|hit_vec) && free_found;
    assign bus.req_ready    = alloc;
    assign bus.req_conflict = bus.req_valid && (|hit_vec);

    // The writeback store owns the port while mem_busy is high, so any
    // response seen then belongs to it and must not bind to an entry.
    assign issue     = !bus.mem_busy && issue_found;
    assign issue_ack = issue && (bus.Dmem2proc_response != 4'h0);

    always_comb begin
        bus.proc2Dmem_command = BUS_NONE;
        bus.proc2Dmem_addr    = '0;
        if (issue) begin
            bus.proc2Dmem_command = BUS_LOAD;
            bus.proc2Dmem_addr    = entry_q[issue_idx].addr;
        end
    end

    // Entry updates: completion, issue and allocation touch disjoint states
    // (WAIT_DATA, WAIT_ISSUE, INVALID), so they never collide on one entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                if (done_vec[i]) begin
                    entry_q[i].state <= INVALID;
                end
                if (issue_ack && (issue_idx == IDX_W'(i))) begin
                    entry_q[i].state   <= WAIT_DATA;
                    entry_q[i].mem_tag <= bus.Dmem2proc_response;
                end
                if (alloc && (free_idx == IDX_W'(i))) begin
                    entry_q[i].state   <= WAIT_ISSUE;
                    entry_q[i].addr    <= req_blk;
                    entry_q[i].lsq_idx <= MSHR_LSQ_IDX_MAX_W'(bus.req_lsq_idx);
                    entry_q[i].mem_tag <= 4'h0;
                end
            end
        end
    end

    // Fill registers: one-cycle pulse per matched completion, payload held otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_valid_q   <= 1'b0;
            fill_addr_q    <= '0;
            fill_data_q    <= '0;
            fill_lsq_idx_q <= '0;
        end else begin
            fill_valid_q <= done_found;
            if (done_found) begin
                fill_addr_q    <= entry_q[done_idx].addr;
                fill_data_q    <= bus.Dmem2proc_data;
                fill_lsq_idx_q <= LSQ_IDX_W'(entry_q[done_idx].lsq_idx);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(alloc) - OCC_W'(done_found);
        end
    end

    assign bus.fill_valid   = fill_valid_q;
    assign bus.fill_addr    = fill_addr_q;
    assign bus.fill_data    = fill_data_q;
    assign bus.fill_lsq_idx = fill_lsq_idx_q;
    assign bus.occupancy    = occ_q;
    assign bus.full         = (occ_q == OCC_W'(NUM_MSHR));

    // Structural invariants: live tags are unique, pending blocks are unique.
    always_comb begin
        dup_tag  = 1'b0;
        dup_addr = 1'b0;
        for (int i = 0; i < NUM_MSHR; i++) begin
            for (int j = i + 1; j < NUM_MSHR; j++) begin
                if ((entry_q[i].state == WAIT_DATA) && (entry_q[j].state == WAIT_DATA) &&
                    (entry_q[i].mem_tag == entry_q[j].mem_tag)) begin
                    dup_tag = 1'b1;
                end
                if ((entry_q[i].state != INVALID) && (entry_q[j].state != INVALID) &&
                    (entry_q[i].addr == entry_q[j].addr)) begin
                    dup_addr = 1'b1;
                end
            end
        end
    end

    always @(posedge clock) begin
        if (!reset) begin
            assert (!dup_tag);
            assert (!dup_addr);
        end
    end

endmodule

// File: tb/tb_dcache_mshr.sv
`timescale 1ns/1ps
module tb_dcache_mshr;
    import dcache_mshr_pkg::*;

    localparam int N  = 4;
    localparam int LW = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dcache_mshr_if #(.NUM_MSHR(N), .LSQ_IDX_W(LW)) bus ();

    dcache_mshr #(.NUM_MSHR(N), .LSQ_IDX_W(LW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a set of slots, each either empty or holding a pending
    // block that is either not yet accepted by memory or waiting on a tag.
    bit            m_live [N];
    bit            m_sent [N];
    logic [63:0]   m_blk  [N];
    logic [LW-1:0] m_idx  [N];
    logic [3:0]    m_tag  [N];
    bit            m_fv;
    logic [63:0]   m_faddr, m_fdata;
    logic [LW-1:0] m_fidx;

    typedef struct {
        bit          rv;
        logic [63:0] ra;
        int          ri;
        bit          busy;
        int          resp;
        int          tag;
        logic [63:0] data;
        bit          e_rdy;
        bit          e_cf;
        bit          e_load;
        logic [63:0] e_addr;
        bit          e_fv;
        logic [63:0] e_faddr;
        logic [63:0] e_fdata;
        int          e_fidx;
        int          e_occ;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] blk_of(input logic [63:0] a);
        return a & ~64'h7;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_live[i] = 1'b0;
            m_sent[i] = 1'b0;
            m_blk[i]  = '0;
            m_idx[i]  = '0;
            m_tag[i]  = '0;
        end
        m_fv    = 1'b0;
        m_faddr = '0;
        m_fdata = '0;
        m_fidx  = '0;
    endtask

    task automatic drive(input bit rv, input logic [63:0] ra, input int ri, input bit busy,
                         input int resp, input int tag, input logic [63:0] data);
        bus.req_valid          = rv;
        bus.req_addr           = ra;
        bus.req_lsq_idx        = LW'(ri);
        bus.mem_busy           = busy;
        bus.Dmem2proc_response = 4'(resp);
        bus.Dmem2proc_tag      = 4'(tag);
        bus.Dmem2proc_data     = data;
    endtask

    // Compare every output against the model for the inputs now applied, then
    // advance the model by the clock edge that follows.
    task automatic model_step();
        bit          conflict;
        bit          ready;
        int          slot;
        int          iss;
        int          cmp;
        int          occ;
        logic [63:0] rb;
        logic [63:0] iaddr;
        conflict = 1'b0;
        slot = -1;
        iss  = -1;
        cmp  = -1;
        occ  = 0;
        rb   = blk_of(bus.req_addr);
        for (int i = 0; i < N; i++) begin
            if (m_live[i]) begin
                occ++;
                if (m_blk[i] == rb) conflict = 1'b1;
                if (!m_sent[i] && iss < 0) iss = i;
                if (m_sent[i] && bus.Dmem2proc_tag != 4'h0 && m_tag[i] == bus.Dmem2proc_tag) cmp = i;
            end else if (slot < 0) begin
                slot = i;
            end
        end
        conflict = conflict && bus.req_valid;
        ready    = bus.req_valid && !conflict && (slot >= 0);
        if (bus.mem_busy) iss = -1;
        iaddr = (iss >= 0) ? m_blk[iss] : 64'h0;

        chk("m_req_ready", 64'(bus.req_ready), 64'(ready));
        chk("m_req_conflict", 64'(bus.req_conflict), 64'(conflict));
        chk("m_command", 64'(bus.proc2Dmem_command), (iss >= 0) ? 64'(BUS_LOAD) : 64'(BUS_NONE));
        chk("m_issue_addr", bus.proc2Dmem_addr, iaddr);
        chk("m_fill_valid", 64'(bus.fill_valid), 64'(m_fv));
        if (m_fv) begin
            chk("m_fill_addr", bus.fill_addr, m_faddr);
            chk("m_fill_data", bus.fill_data, m_fdata);
            chk("m_fill_idx", 64'(bus.fill_lsq_idx), 64'(m_fidx));
        end
        chk("m_occupancy", 64'(bus.occupancy), 64'(occ));
        chk("m_full", 64'(bus.full), 64'(occ == N));

        m_fv = (cmp >= 0);
        if (cmp >= 0) begin
            m_faddr = m_blk[cmp];
            m_fdata = bus.Dmem2proc_data;
            m_fidx  = m_idx[cmp];
            m_live[cmp] = 1'b0;
        end
        if (iss >= 0 && bus.Dmem2proc_response != 4'h0) begin
            m_sent[iss] = 1'b1;
            m_tag[iss]  = bus.Dmem2proc_response;
        end
        if (ready) begin
            m_live[slot] = 1'b1;
            m_sent[slot] = 1'b0;
            m_blk[slot]  = rb;
            m_idx[slot]  = bus.req_lsq_idx;
        end
    endtask

    task automatic cycle(input bit rv, input logic [63:0] ra, input int ri, input bit busy,
                         input int resp, input int tag, input logic [63:0] data);
        @(negedge clock);
        drive(rv, ra, ri, busy, resp, tag, data);
        #1;
        model_step();
    endtask

    // Reset lands mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic async_reset();
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_occupancy", 64'(bus.occupancy), 64'h0);
        chk("rst_full", 64'(bus.full), 64'h0);
        chk("rst_fill_valid", 64'(bus.fill_valid), 64'h0);
        chk("rst_fill_addr", bus.fill_addr, 64'h0);
        chk("rst_fill_data", bus.fill_data, 64'h0);
        chk("rst_fill_idx", 64'(bus.fill_lsq_idx), 64'h0);
        chk("rst_command", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic int free_tag(input int excl);
        int start;
        start = int'($urandom_range(15, 1));
        for (int k = 0; k < 15; k++) begin
            int t;
            bit used;
            t    = ((start - 1 + k) % 15) + 1;
            used = (t == excl);
            for (int i = 0; i < N; i++) begin
                if (m_live[i] && m_sent[i] && int'(m_tag[i]) == t) used = 1'b1;
            end
            if (!used) return t;
        end
        return 0;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        //          rv  addr        ri busy resp tag data      | rdy cf ld  addr       fv faddr      fdata      fi occ
        tbl[0]  = '{1, 64'h1008,  2, 0,   0,   0,  64'h0,     1,  0, 0, 64'h0,     0, 64'h0,     64'h0,     0, 0};
        tbl[1]  = '{0, 64'h0,     0, 0,   5,   0,  64'h0,     0,  0, 1, 64'h1008,  0, 64'h0,     64'h0,     0, 1};
        tbl[2]  = '{0, 64'h0,     0, 0,   0,   0,  64'h0,     0,  0, 0, 64'h0,     0, 64'h0,     64'h0,     0, 1};
        tbl[3]  = '{0, 64'h0,     0, 0,   0,   0,  64'h0,     0,  0, 0, 64'h0,     0, 64'h0,     64'h0,     0, 1};
        tbl[4]  = '{0, 64'h0,     0, 0,   0,   5,  64'hDEAD,  0,  0, 0, 64'h0,     0, 64'h0,     64'h0,     0, 1};
        tbl[5]  = '{0, 64'h0,     0, 0,   0,   0,  64'h0,     0,  0, 0, 64'h0,     1, 64'h1008,  64'hDEAD,  2, 0};
        tbl[6]  = '{0, 64'h0,     0, 0,   0,   0,  64'h0,     0,  0, 0, 64'h0,     0, 64'h0,     64'h0,     0, 0};
        tbl[7]  = '{1, 64'h2000,  1, 0,   0,   0,  64'h0,     1,  0, 0, 64'h0,     0, 64'h0,     64'h0,     0, 0};
        tbl[8]  = '{0, 64'h0,     0, 0,   0,   0,  64'h0,     0,  0, 1, 64'h2000,  0, 64'h0,     64'h0,     0, 1};
        tbl[9]  = '{0, 64'h0,     0, 0,   0,   0,  64'h0,     0,  0, 1, 64'h2000,  0, 64'h0,     64'h0,     0, 1};
        tbl[10] = '{0, 64'h0,     0, 0,   7,   0,  64'h0,     0,  0, 1, 64'h2000,  0, 64'h0,     64'h0,     0, 1};
        tbl[11] = '{0, 64'h0,     0, 0,   0,   0,  64'h0,     0,  0, 0, 64'h0,     0, 64'h0,     64'h0,     0, 1};
        tbl[12] = '{0, 64'h0,     0, 0,   0,   7,  64'h77,    0,  0, 0, 64'h0,     0, 64'h0,     64'h0,     0, 1};
        tbl[13] = '{0, 64'h0,     0, 0,   0,   0,  64'h0,     0,  0, 0, 64'h0,     1, 64'h2000,  64'h77,    1, 0};

        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        reset = 1'b1;
        #1;
        chk("init_occupancy", 64'(bus.occupancy), 64'h0);
        chk("init_full", 64'(bus.full), 64'h0);
        chk("init_fill_valid", 64'(bus.fill_valid), 64'h0);
        chk("init_command", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Single miss lifecycle and rejected-then-accepted issue.
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            drive(tbl[k].rv, tbl[k].ra, tbl[k].ri, tbl[k].busy, tbl[k].resp, tbl[k].tag, tbl[k].data);
            #1;
            chk($sformatf("t%0d_req_ready", k), 64'(bus.req_ready), 64'(tbl[k].e_rdy));
            chk($sformatf("t%0d_req_conflict", k), 64'(bus.req_conflict), 64'(tbl[k].e_cf));
            chk($sformatf("t%0d_command", k), 64'(bus.proc2Dmem_command),
                tbl[k].e_load ? 64'(BUS_LOAD) : 64'(BUS_NONE));
            chk($sformatf("t%0d_issue_addr", k), bus.proc2Dmem_addr, tbl[k].e_addr);
            chk($sformatf("t%0d_fill_valid", k), 64'(bus.fill_valid), 64'(tbl[k].e_fv));
            if (tbl[k].e_fv) begin
                chk($sformatf("t%0d_fill_addr", k), bus.fill_addr, tbl[k].e_faddr);
                chk($sformatf("t%0d_fill_data", k), bus.fill_data, tbl[k].e_fdata);
                chk($sformatf("t%0d_fill_idx", k), 64'(bus.fill_lsq_idx), 64'(tbl[k].e_fidx));
            end
            chk($sformatf("t%0d_occupancy", k), 64'(bus.occupancy), 64'(tbl[k].e_occ));
            chk($sformatf("t%0d_full", k), 64'(bus.full), 64'(tbl[k].e_occ == N));
            model_step();
        end

        // Fill all entries, refuse when full, reuse only after the freeing edge.
        cycle(1, 64'h100, 0, 1, 0, 0, 0);
        cycle(1, 64'h200, 1, 0, 3, 0, 0);
        cycle(1, 64'h300, 2, 0, 0, 0, 0);
        cycle(1, 64'h400, 3, 1, 0, 0, 0);
        cycle(1, 64'h1004, 4, 1, 0, 0, 0);
        chk("full_flag", 64'(bus.full), 64'h1);
        chk("full_ready", 64'(bus.req_ready), 64'h0);
        chk("full_conflict", 64'(bus.req_conflict), 64'h0);
        cycle(1, 64'h1004, 4, 1, 0, 3, 64'h33);
        chk("free_same_cycle_ready", 64'(bus.req_ready), 64'h0);
        cycle(1, 64'h1004, 4, 1, 0, 0, 0);
        chk("free_next_ready", 64'(bus.req_ready), 64'h1);
        chk("free_next_full", 64'(bus.full), 64'h0);
        chk("free_fill_addr", bus.fill_addr, 64'h100);
        // Same block as the pending 0x1004 miss.
        cycle(1, 64'h1000, 5, 1, 0, 0, 0);
        chk("conflict_flag", 64'(bus.req_conflict), 64'h1);
        chk("conflict_ready", 64'(bus.req_ready), 64'h0);
        chk("conflict_occ", 64'(bus.occupancy), 64'h4);
        // mem_busy holds issue off; first idle cycle issues the lowest pending entry.
        cycle(0, 0, 0, 1, 6, 0, 0);
        chk("busy_command", 64'(bus.proc2Dmem_command), 64'(BUS_NONE));
        chk("busy_occ", 64'(bus.occupancy), 64'h4);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("unbusy_command", 64'(bus.proc2Dmem_command), 64'(BUS_LOAD));
        chk("unbusy_addr", bus.proc2Dmem_addr, 64'h1000);
        async_reset();

        // Out-of-order completion, unmatched tag, reset while waiting on data.
        cycle(1, 64'h2000, 6, 1, 0, 0, 0);
        cycle(1, 64'h4000, 3, 0, 2, 0, 0);
        cycle(0, 0, 0, 0, 4, 0, 0);
        chk("ooo_issue_addr", bus.proc2Dmem_addr, 64'h4000);
        cycle(0, 0, 0, 0, 0, 4, 64'h44);
        cycle(0, 0, 0, 0, 0, 2, 64'h22);
        chk("ooo_fill1_valid", 64'(bus.fill_valid), 64'h1);
        chk("ooo_fill1_addr", bus.fill_addr, 64'h4000);
        chk("ooo_fill1_data", bus.fill_data, 64'h44);
        chk("ooo_fill1_idx", 64'(bus.fill_lsq_idx), 64'h3);
        cycle(0, 0, 0, 0, 0, 9, 64'h99);
        chk("ooo_fill2_addr", bus.fill_addr, 64'h2000);
        chk("ooo_fill2_data", bus.fill_data, 64'h22);
        chk("ooo_fill2_idx", 64'(bus.fill_lsq_idx), 64'h6);
        cycle(1, 64'h6000, 1, 0, 0, 0, 0);
        chk("unmatched_fill_valid", 64'(bus.fill_valid), 64'h0);
        cycle(0, 0, 0, 0, 5, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("pre_reset_occ", 64'(bus.occupancy), 64'h1);
        async_reset();
        cycle(0, 0, 0, 0, 0, 5, 64'h55);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("stale_tag_fill_valid", 64'(bus.fill_valid), 64'h0);
        chk("stale_tag_occ", 64'(bus.occupancy), 64'h0);

        // Randomized traffic over a small block pool so conflicts and full occur.
        for (int c = 0; c < 3000; c++) begin
            int q[$];
            int tg;
            int rs;
            q.delete();
            for (int i = 0; i < N; i++) begin
                if (m_live[i] && m_sent[i]) q.push_back(int'(m_tag[i]));
            end
            tg = 0;
            case ($urandom % 4)
                0, 1: if (q.size() > 0) tg = q[$urandom % q.size()];
                2: tg = free_tag(0);
                default: tg = 0;
            endcase
            rs = (($urandom % 3) == 0) ? 0 : free_tag(tg);
            cycle(1'($urandom % 2), 64'h8000 + 64'(($urandom % 8) * 8) + 64'($urandom % 8),
                  int'($urandom % 8), 1'(($urandom % 4) == 0), rs, tg, {$urandom, $urandom});
            if ((c % 700) == 699) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
